// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two requesters, the shared ALU and the response consumer.
// The arbiter takes the slave view; whatever surrounds it takes the master view.
interface alu_arbiter_if #(
    parameter int DW = 32
);
    logic          req0_valid;
    logic          req0_ready;
    logic [2:0]    req0_op;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic          req1_valid;
    logic          req1_ready;
    logic [2:0]    req1_op;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_r;
    logic          alu_z;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [DW-1:0] rsp_r;
    logic          rsp_z;
    logic          rsp_err;
    logic          busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_r, alu_z, rsp_ready,
        output req0_ready, req1_ready,
        output alu_op, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_r, rsp_z, rsp_err, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_r, alu_z, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_r, rsp_z, rsp_err, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin front end for one shared combinational ALU: accepts one op at a time,
// holds operands on the ALU through the execute window, then returns the result.
module alu_arbiter #(
    parameter int DW         = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    // A zero-width counter is illegal, so keep at least one bit when MUL_CYCLES is 0.
    localparam int CW = (MUL_CYCLES > 0) ? $clog2(MUL_CYCLES + 1) : 1;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        r_state;
    logic          r_rr;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_alu_op;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic          r_rsp_valid;
    logic          r_rsp_id;
    logic [DW-1:0] r_rsp_r;
    logic          r_rsp_z;
    logic          r_rsp_err;

    logic          w_grant0;
    logic          w_grant1;
    logic [2:0]    w_op;
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == IDLE) begin
            w_grant0 = bus.req0_valid && (!bus.req1_valid || r_rr);
            w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_rr);
        end
    end

    assign w_op = w_grant1 ? bus.req1_op : bus.req0_op;
    assign w_a  = w_grant1 ? bus.req1_a  : bus.req0_a;
    assign w_b  = w_grant1 ? bus.req1_b  : bus.req0_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr        <= 1'b1;
            r_cnt       <= '0;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_r     <= '0;
            r_rsp_z     <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_alu_op <= w_op;
                        r_alu_a  <= w_a;
                        r_alu_b  <= w_b;
                        r_rsp_id <= w_grant1;
                        r_rr     <= w_grant1;
                        r_cnt    <= (w_op == OP_MUL) ? CW'(MUL_CYCLES) : '0;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt == '0) begin
                        r_rsp_r     <= bus.alu_r;
                        r_rsp_z     <= bus.alu_z;
                        r_rsp_err   <= (r_alu_op == 3'b000) || (r_alu_op == 3'b111);
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.alu_op     = r_alu_op;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_r      = r_rsp_r;
    assign bus.rsp_z      = r_rsp_z;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.busy       = (r_state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU sits on the ALU side of the bus,
// and each task drives one scenario and checks hand-computed results inline.
module tb_alu_arbiter;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    alu_arbiter_if #(.DW(32)) bus ();

    alu_arbiter #(.DW(32), .MUL_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU.
    logic [31:0] alu_res;
    always_comb begin
        alu_res = 32'd0;
        case (bus.alu_op)
            3'b001:  alu_res = bus.alu_a + bus.alu_b;
            3'b010:  alu_res = bus.alu_a & bus.alu_b;
            3'b011:  alu_res = bus.alu_a | bus.alu_b;
            3'b100:  alu_res = bus.alu_a * bus.alu_b;
            3'b101:  alu_res = bus.alu_a - bus.alu_b;
            3'b110:  alu_res = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            default: alu_res = 32'd0;
        endcase
    end
    assign bus.alu_r = alu_res;
    assign bus.alu_z = (alu_res == 32'd0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until the handshake edge; returns just after that edge.
    task automatic send(input bit id, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output bit ok);
        ok = 1'b0;
        if (id == 1'b0) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if ((id == 1'b0 && bus.req0_ready) || (id == 1'b1 && bus.req1_ready)) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_total++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_id !== 1'b0 ||
            bus.rsp_z !== 1'b0 || bus.rsp_err !== 1'b0)
            $display("FAIL reset_flags: valid=%b busy=%b id=%b z=%b err=%b, required all 0",
                     bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_z, bus.rsp_err);
        else n_pass++;
        n_total++;
        if (bus.rsp_r !== 32'd0 || bus.alu_op !== 3'd0 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0)
            $display("FAIL reset_data: rsp_r=%h alu_op=%h alu_a=%h alu_b=%h, required 0",
                     bus.rsp_r, bus.alu_op, bus.alu_a, bus.alu_b);
        else n_pass++;
        n_total++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
            $display("FAIL reset_ready: r0=%b r1=%b, required 0 0", bus.req0_ready, bus.req1_ready);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        bit ok;
        bus.rsp_ready = 1'b1;
        send(1'b0, 3'b001, 32'd5, 32'd7, ok);
        n_total++;
        if (!ok) $display("FAIL add_grant: no handshake within bound");
        else n_pass++;
        n_total++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7)
            $display("FAIL add_exec: valid=%b busy=%b a=%0d b=%0d, required 0 1 5 7",
                     bus.rsp_valid, bus.busy, bus.alu_a, bus.alu_b);
        else n_pass++;
        tick();
        n_total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_r !== 32'd12 || bus.rsp_z !== 1'b0 ||
            bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0)
            $display("FAIL add_rsp: valid=%b r=%0d z=%b id=%b err=%b, required 1 12 0 0 0",
                     bus.rsp_valid, bus.rsp_r, bus.rsp_z, bus.rsp_id, bus.rsp_err);
        else n_pass++;
        $display("txn add id=%0d r=%0d z=%b", bus.rsp_id, bus.rsp_r, bus.rsp_z);
        tick();
        n_total++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL add_done: valid=%b busy=%b, required 0 0", bus.rsp_valid, bus.busy);
        else n_pass++;
    endtask

    task automatic test_sub_slt();
        bit ok;
        send(1'b1, 3'b101, 32'd9, 32'd9, ok);
        tick();
        n_total++;
        if (!ok || bus.rsp_valid !== 1'b1 || bus.rsp_r !== 32'd0 || bus.rsp_z !== 1'b1 || bus.rsp_id !== 1'b1)
            $display("FAIL sub_rsp: ok=%b valid=%b r=%0d z=%b id=%b, required 1 1 0 1 1",
                     ok, bus.rsp_valid, bus.rsp_r, bus.rsp_z, bus.rsp_id);
        else n_pass++;
        $display("txn sub id=%0d r=%0d z=%b", bus.rsp_id, bus.rsp_r, bus.rsp_z);
        tick();
        send(1'b1, 3'b110, 32'd3, 32'd4, ok);
        tick();
        n_total++;
        if (!ok || bus.rsp_valid !== 1'b1 || bus.rsp_r !== 32'd1 || bus.rsp_z !== 1'b0 || bus.rsp_id !== 1'b1)
            $display("FAIL slt_rsp: ok=%b valid=%b r=%0d z=%b id=%b, required 1 1 1 0 1",
                     ok, bus.rsp_valid, bus.rsp_r, bus.rsp_z, bus.rsp_id);
        else n_pass++;
        $display("txn slt id=%0d r=%0d z=%b", bus.rsp_id, bus.rsp_r, bus.rsp_z);
        tick();
    endtask

    task automatic test_round_robin();
        bit exp_id;
        bit seen;
        bus.req0_valid = 1'b1; bus.req0_op = 3'b001; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
        bus.req1_valid = 1'b1; bus.req1_op = 3'b001; bus.req1_a = 32'd2; bus.req1_b = 32'd2;
        for (int n = 0; n < 4; n++) begin
            exp_id = n[0];
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                if (bus.req0_ready || bus.req1_ready) seen = 1'b1;
                else @(posedge clk);
            end
            n_total++;
            if (!seen || bus.req0_ready !== !exp_id || bus.req1_ready !== exp_id)
                $display("FAIL rr_grant%0d: r0=%b r1=%b, required r0=%b r1=%b",
                         n, bus.req0_ready, bus.req1_ready, !exp_id, exp_id);
            else n_pass++;
            @(posedge clk);
            #1;
            tick();
            n_total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_id ||
                bus.rsp_r !== (exp_id ? 32'd4 : 32'd2))
                $display("FAIL rr_rsp%0d: valid=%b id=%b r=%0d, required 1 %b %0d",
                         n, bus.rsp_valid, bus.rsp_id, bus.rsp_r, exp_id, exp_id ? 4 : 2);
            else n_pass++;
            $display("txn rr%0d id=%0d r=%0d", n, bus.rsp_id, bus.rsp_r);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        bit ok;
        send(1'b0, 3'b100, 32'd6, 32'd7, ok);
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (!ok || bus.rsp_valid !== 1'b0 || bus.alu_op !== 3'b100 ||
                bus.alu_a !== 32'd6 || bus.alu_b !== 32'd7)
                $display("FAIL mul_exec%0d: ok=%b valid=%b op=%b a=%0d b=%0d, required 1 0 100 6 7",
                         i, ok, bus.rsp_valid, bus.alu_op, bus.alu_a, bus.alu_b);
            else n_pass++;
            tick();
        end
        n_total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_r !== 32'd42 || bus.rsp_id !== 1'b0 ||
            bus.alu_a !== 32'd6 || bus.alu_b !== 32'd7)
            $display("FAIL mul_rsp: valid=%b r=%0d id=%b a=%0d b=%0d, required 1 42 0 6 7",
                     bus.rsp_valid, bus.rsp_r, bus.rsp_id, bus.alu_a, bus.alu_b);
        else n_pass++;
        $display("txn mul id=%0d r=%0d", bus.rsp_id, bus.rsp_r);
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        bus.rsp_ready = 1'b0;
        send(1'b1, 3'b001, 32'd10, 32'd20, ok);
        tick();
        bus.req0_valid = 1'b1; bus.req0_op = 3'b001; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            if (!ok || bus.rsp_valid !== 1'b1 || bus.rsp_r !== 32'd30 || bus.rsp_id !== 1'b1 ||
                bus.rsp_z !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
                $display("FAIL hold%0d: ok=%b valid=%b r=%0d id=%b z=%b r0=%b r1=%b, required 1 1 30 1 0 0 0",
                         i, ok, bus.rsp_valid, bus.rsp_r, bus.rsp_id, bus.rsp_z,
                         bus.req0_ready, bus.req1_ready);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        $display("txn hold id=%0d r=%0d", bus.rsp_id, bus.rsp_r);
        bus.req0_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        tick();
        n_total++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL hold_release: valid=%b busy=%b, required 0 0", bus.rsp_valid, bus.busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_exec();
        bit ok;
        bit any_rsp;
        send(1'b1, 3'b100, 32'd3, 32'd3, ok);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (!ok || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.alu_a !== 32'd0 || bus.alu_op !== 3'd0)
            $display("FAIL rst_exec: ok=%b valid=%b busy=%b a=%0d op=%b, required 1 0 0 0 000",
                     ok, bus.rsp_valid, bus.busy, bus.alu_a, bus.alu_op);
        else n_pass++;
        any_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.rsp_valid) any_rsp = 1'b1;
        end
        n_total++;
        if (any_rsp !== 1'b0)
            $display("FAIL rst_norsp: saw rsp_valid=%b, required 0", any_rsp);
        else n_pass++;
        bus.req0_valid = 1'b1; bus.req0_op = 3'b001; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
        bus.req1_valid = 1'b1; bus.req1_op = 3'b001; bus.req1_a = 32'd8; bus.req1_b = 32'd8;
        @(negedge clk);
        n_total++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
            $display("FAIL rst_tie: r0=%b r1=%b, required 1 0", bus.req0_ready, bus.req1_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        n_total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_r !== 32'd3)
            $display("FAIL rst_next: valid=%b id=%b r=%0d, required 1 0 3",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_r);
        else n_pass++;
        $display("txn post_rst id=%0d r=%0d", bus.rsp_id, bus.rsp_r);
        tick();
    endtask

    task automatic test_undef();
        bit ok;
        send(1'b0, 3'b111, 32'd5, 32'd3, ok);
        tick();
        n_total++;
        if (!ok || bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_r !== 32'd0 || bus.rsp_z !== 1'b1)
            $display("FAIL undef_rsp: ok=%b valid=%b err=%b r=%0d z=%b, required 1 1 1 0 1",
                     ok, bus.rsp_valid, bus.rsp_err, bus.rsp_r, bus.rsp_z);
        else n_pass++;
        $display("txn undef id=%0d err=%b r=%0d z=%b", bus.rsp_id, bus.rsp_err, bus.rsp_r, bus.rsp_z);
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
        bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
        bus.rsp_ready  = 1'b0;
        test_reset();
        test_add();
        test_sub_slt();
        test_round_robin();
        test_mul();
        test_backpressure();
        test_reset_mid_exec();
        test_undef();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule
